// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, sends one byte with odd parity
// clocked by the device, then checks the device ACK. Drives the lines through open-drain enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_BITS,
    S_WAIT_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  logic fall;

  always_comb begin
    clk_meta_d  = ps2_clk_i;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_i;
    data_sync_d = data_meta_q;
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    par_d     = par_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          data_d  = tx_data;
          par_d   = ~^tx_data;
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_START: begin
        data_oe_d = 1'b1;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = S_BITS;
      end

      S_BITS: begin
        if (fall) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Fall n puts bit n-1 on the line; fall 9 parity, fall 10 releases for the stop bit.
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~par_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = S_WAIT_ACK;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_ACK: begin
        data_oe_d = 1'b0;
        if (fall) begin
          cnt_d = '0;
          if (!data_sync_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      // Idle bus level is high, so no spurious fall is seen right after reset.
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_q       <= par_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
  assign ps2_data_oe = data_oe_q;

endmodule
